// File: rtl/board_debug_monitor_if.sv
// Board-side bundle for board_debug_monitor: raw keys/switches, probe taps and core
// handshake in, core clock-enable and display drive out.
interface board_debug_monitor_if #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 32,
    parameter int LED_W  = 10
);
    logic [3:0]             key_n;
    logic [9:0]             sw;
    logic [NUM_CH*DATA_W-1:0] probe_data;
    logic                   cpu_completed;
    logic                   cpu_clk_en;
    logic [LED_W-1:0]       ledr;
    logic [6:0]             hex0;

    modport master (
        output key_n, sw, probe_data, cpu_completed,
        input  cpu_clk_en, ledr, hex0
    );

    modport slave (
        input  key_n, sw, probe_data, cpu_completed,
        output cpu_clk_en, ledr, hex0
    );
endinterface

// File: rtl/board_debug_monitor.sv
// Debug/run controller: free-run or single-step clock-enable for the core, probe
// channel display on LEDs/HEX0. Define DBG_CYCLE_COUNT_EN to add a cycle-count channel.
module board_debug_monitor #(
    parameter int DIV_BITS        = 25,
    parameter int NUM_CH          = 8,
    parameter int DATA_W          = 32,
    parameter int LED_W           = 10,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input logic                CLK,
    input logic                RSTN,
    board_debug_monitor_if.slave bus
);
`ifdef DBG_CYCLE_COUNT_EN
    localparam int NCH_EFF = NUM_CH + 1;
`else
    localparam int NCH_EFF = NUM_CH;
`endif
    localparam int CH_W  = $clog2(NUM_CH + 1);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PAD_A = (DATA_W > 4*LED_W) ? DATA_W : 4*LED_W;
    localparam int PAD_W = (PAD_A > 32) ? PAD_A : 32;

    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_STEP, ST_DONE} state_t;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_seg = 7'b1000000;  4'h1: hex_seg = 7'b1111001;
            4'h2: hex_seg = 7'b0100100;  4'h3: hex_seg = 7'b0110000;
            4'h4: hex_seg = 7'b0011001;  4'h5: hex_seg = 7'b0010010;
            4'h6: hex_seg = 7'b0000010;  4'h7: hex_seg = 7'b1111000;
            4'h8: hex_seg = 7'b0000000;  4'h9: hex_seg = 7'b0010000;
            4'hA: hex_seg = 7'b0001000;  4'hB: hex_seg = 7'b0000011;
            4'hC: hex_seg = 7'b1000110;  4'hD: hex_seg = 7'b0100001;
            4'hE: hex_seg = 7'b0000110;  default: hex_seg = 7'b0001110;
        endcase
    endfunction

    logic [3:0]      key_s1_q, key_s2_q, key_db_q, key_db_d, press_q;
    logic [3:0]      sw_s1_q, sw_s2_q;
    logic [DB_W-1:0] db_cnt_q [4];
    logic [DB_W-1:0] db_cnt_d [4];
    logic [CH_W-1:0] ch_sel_q, ch_sel_d;
    state_t          state_q;
    logic [DIV_BITS-1:0] div_q;
    logic            en_q;
    logic [LED_W-1:0] ledr_q;
    logic [6:0]      hex0_q;
    logic [PAD_W-1:0] win_src;
    logic [CH_W-1:0] ch_idx;
    logic            unused_ok;

    assign unused_ok = ^{bus.sw[9:4], sw_s2_q[1], press_q[1]};

    // A key flips only after DEBOUNCE_CYCLES consecutive samples disagree with it.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            key_db_d[k] = key_db_q[k];
            db_cnt_d[k] = '0;
            if (key_s2_q[k] != key_db_q[k]) begin
                if (db_cnt_q[k] == DB_W'(DEBOUNCE_CYCLES - 1))
                    key_db_d[k] = key_s2_q[k];
                else
                    db_cnt_d[k] = db_cnt_q[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            key_s1_q <= 4'hF;
            key_s2_q <= 4'hF;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            key_db_q <= 4'hF;
            press_q  <= '0;
            for (int k = 0; k < 4; k++) db_cnt_q[k] <= '0;
        end else begin
            key_s1_q <= bus.key_n;
            key_s2_q <= key_s1_q;
            sw_s1_q  <= bus.sw[3:0];
            sw_s2_q  <= sw_s1_q;
            key_db_q <= key_db_d;
            press_q  <= key_db_q & ~key_db_d;
            for (int k = 0; k < 4; k++) db_cnt_q[k] <= db_cnt_d[k];
        end
    end

    always_comb begin
        ch_sel_d = ch_sel_q;
        if (press_q[3] && !press_q[2])
            ch_sel_d = (ch_sel_q == CH_W'(NCH_EFF - 1)) ? '0 : ch_sel_q + 1'b1;
        else if (press_q[2] && !press_q[3])
            ch_sel_d = (ch_sel_q == '0) ? CH_W'(NCH_EFF - 1) : ch_sel_q - 1'b1;
    end

    // Completion overrides everything and is sticky until reset.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= ST_STOP;
            div_q    <= '0;
            en_q     <= 1'b0;
            ch_sel_q <= '0;
        end else begin
            ch_sel_q <= ch_sel_d;
            if (bus.cpu_completed) begin
                state_q <= ST_DONE;
                en_q    <= 1'b0;
                div_q   <= '0;
            end else begin
                case (state_q)
                    ST_STOP: begin
                        en_q  <= 1'b0;
                        div_q <= '0;
                        if (sw_s2_q[0]) begin
                            state_q <= ST_RUN;
                        end else if (press_q[0]) begin
                            state_q <= ST_STEP;
                            en_q    <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (!sw_s2_q[0]) begin
                            state_q <= ST_STOP;
                            div_q   <= '0;
                            en_q    <= 1'b0;
                        end else begin
                            div_q <= div_q + 1'b1;
                            en_q  <= &div_q;
                        end
                    end
                    ST_STEP: begin
                        en_q    <= 1'b0;
                        state_q <= ST_STOP;
                    end
                    default: en_q <= 1'b0;
                endcase
            end
        end
    end

    assign bus.cpu_clk_en = en_q & ~bus.cpu_completed;

`ifdef DBG_CYCLE_COUNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        sat_inc = (&v) ? v : v + 32'd1;
    endfunction

    logic [31:0] cyc_q;
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)               cyc_q <= '0;
        else if (bus.cpu_clk_en) cyc_q <= sat_inc(cyc_q);
    end
`endif

    assign ch_idx = (ch_sel_q < CH_W'(NUM_CH)) ? ch_sel_q : '0;

    // Zero-extend so windows reaching past DATA_W read as zeros.
    always_comb begin
        win_src = PAD_W'(bus.probe_data[ch_idx*DATA_W +: DATA_W]);
`ifdef DBG_CYCLE_COUNT_EN
        if (ch_sel_q == CH_W'(NUM_CH)) win_src = PAD_W'(cyc_q);
`endif
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ledr_q <= '0;
            hex0_q <= 7'h7F;
        end else begin
            ledr_q <= win_src[sw_s2_q[3:2]*LED_W +: LED_W];
            if (state_q == ST_DONE)
                hex0_q <= 7'b0100001;
`ifdef DBG_CYCLE_COUNT_EN
            else if (ch_sel_q == CH_W'(NUM_CH))
                hex0_q <= 7'b0100111;
`endif
            else
                hex0_q <= hex_seg(4'(ch_sel_q));
        end
    end

    assign bus.ledr = ledr_q;
    assign bus.hex0 = hex0_q;
endmodule

// File: tb/tb_board_debug_monitor.sv
// Directed bench for board_debug_monitor with a short divider and debounce window.
module tb_board_debug_monitor;
    localparam int DIV_BITS = 4;
    localparam int NUM_CH   = 8;
    localparam int DATA_W   = 32;
    localparam int LED_W    = 10;
    localparam int DEB      = 4;

    logic CLK  = 1'b0;
    logic RSTN = 1'b0;
    always #5 CLK = ~CLK;

    board_debug_monitor_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .LED_W(LED_W)) bus ();

    board_debug_monitor #(
        .DIV_BITS(DIV_BITS), .NUM_CH(NUM_CH), .DATA_W(DATA_W),
        .LED_W(LED_W), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .CLK (CLK),
        .RSTN(RSTN),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int pulses[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles, logging (1-based) the cycles in which cpu_clk_en is high.
    task automatic run(input int n);
        for (int i = 1; i <= n; i++) begin
            @(negedge CLK);
            if (bus.cpu_clk_en === 1'b1) pulses.push_back(i);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic press(input logic [3:0] mask);
        bus.key_n = ~mask;
        wait_cyc(10);
        bus.key_n = 4'hF;
        wait_cyc(10);
    endtask

    initial begin
        bus.key_n         = 4'hF;
        bus.sw            = '0;
        bus.cpu_completed = 1'b0;
        for (int c = 0; c < NUM_CH; c++)
            bus.probe_data[c*DATA_W +: DATA_W] = 32'h1111_1111 * (c + 1);
        bus.probe_data[0*DATA_W +: DATA_W] = 32'h0000_0155;
        bus.probe_data[3*DATA_W +: DATA_W] = 32'hABCD_1234;
        bus.probe_data[4*DATA_W +: DATA_W] = 32'h0000_02AA;

        // Reset values
        wait_cyc(3);
        check("rst_en",   32'(bus.cpu_clk_en), 32'h0);
        check("rst_ledr", 32'(bus.ledr),       32'h0);
        check("rst_hex",  32'(bus.hex0),       32'h7F);
        RSTN = 1'b1;
        wait_cyc(3);
        check("hex_ch0",  32'(bus.hex0), 32'h40);
        check("ledr_ch0", 32'(bus.ledr), 32'h155);

        // Reset asserted in the middle of a run pulse
        pulses.delete();
        bus.sw = 10'h001;
        run(19);
        check("mid_npulse", 32'(pulses.size()), 32'd1);
        check("mid_first",  32'((pulses.size() > 0) ? pulses[0] : -1), 32'd19);
        check("mid_en_hi",  32'(bus.cpu_clk_en), 32'h1);
        RSTN   = 1'b0;
        bus.sw = '0;
        #1;
        check("mid_rst_en",   32'(bus.cpu_clk_en), 32'h0);
        check("mid_rst_ledr", 32'(bus.ledr),       32'h0);
        check("mid_rst_hex",  32'(bus.hex0),       32'h7F);
        wait_cyc(2);
        RSTN = 1'b1;
        pulses.delete();
        run(30);
        check("post_rst_stop", 32'(pulses.size()), 32'd0);
        check("post_rst_hex",  32'(bus.hex0),      32'h40);

        // Free run: 2 sync cycles + 1 entry cycle, then one tick every 16 cycles
        pulses.delete();
        bus.sw = 10'h001;
        run(67);
        check("run_npulse", 32'(pulses.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("run_pulse%0d", k),
                  32'((pulses.size() > k) ? pulses[k] : -1), 32'(19 + 16*k));
        bus.sw = '0;
        pulses.delete();
        run(30);
        check("run_stop", 32'(pulses.size()), 32'd0);

        // Single step with a long hold
        pulses.delete();
        bus.key_n = 4'hE;
        run(40);
        bus.key_n = 4'hF;
        run(20);
        check("step_one", 32'(pulses.size()), 32'd1);

        // Bouncing key never settles long enough
        pulses.delete();
        for (int k = 0; k < 10; k++) begin
            bus.key_n = 4'hE;
            run(2);
            bus.key_n = 4'hF;
            run(2);
        end
        run(20);
        check("bounce_none", 32'(pulses.size()), 32'd0);

        // Channel select wrap and simultaneous keys
        press(4'b0100);
        check("ch_dec_wrap", 32'(bus.hex0), 32'h78);
        press(4'b1000);
        check("ch_inc_wrap", 32'(bus.hex0), 32'h40);
        press(4'b1100);
        check("ch_both",     32'(bus.hex0), 32'h40);
        press(4'b1000);
        check("ch_1",        32'(bus.hex0), 32'h79);
        press(4'b1000);
        press(4'b1000);
        check("ch_3",        32'(bus.hex0), 32'h30);

        // Windows of 32'hABCD1234
        bus.sw = 10'b00_0000_0000; wait_cyc(5);
        check("win0", 32'(bus.ledr), 32'h234);
        bus.sw = 10'b00_0000_0100; wait_cyc(5);
        check("win1", 32'(bus.ledr), 32'h344);
        bus.sw = 10'b00_0000_1000; wait_cyc(5);
        check("win2", 32'(bus.ledr), 32'h2BC);
        bus.sw = 10'b00_0000_1100; wait_cyc(5);
        check("win3", 32'(bus.ledr), 32'h002);

        // Completion lands in the same cycle as a run tick
        bus.sw = 10'h001;
        wait_cyc(18);
        @(posedge CLK);
        #1 bus.cpu_completed = 1'b1;
        @(negedge CLK);
        check("done_gate", 32'(bus.cpu_clk_en), 32'h0);
        wait_cyc(2);
        bus.cpu_completed = 1'b0;
        pulses.delete();
        run(60);
        check("done_nopulse", 32'(pulses.size()), 32'd0);
        check("done_hex",     32'(bus.hex0),      32'h21);
        press(4'b1000);
        check("done_ledr_live", 32'(bus.ledr), 32'h2AA);
        check("done_hex_hold",  32'(bus.hex0), 32'h21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
